// File: rtl/s3_deserializer_if.sv
// Stage-3 bus: a bit strobe plus one serial data bit per strobe.
interface in_MyBus;
    logic execute1;
    logic dataTx1;

    // Consumers only observe the bus
    modport sink (input execute1, input dataTx1);
    // Producers drive both signals
    modport source (output execute1, output dataTx1);
endinterface

// File: rtl/s3_deserializer.sv
// Stage-3 deserializer: assembles LSB-first serial bits into WIDTH-bit words
// and queues them in a DEPTH-entry show-ahead FIFO with a valid/ready output.
// The bus cannot stall, so a word arriving at a full FIFO is dropped and
// recorded in a sticky overflow flag.
module s3_deserializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         ck,
    input  logic                         arst_n,
    input  logic                         isolate,
    in_MyBus.sink                        uin_MyBusS3,
    output logic [WIDTH-1:0]             word_o,
    output logic                         word_vld_o,
    input  logic                         word_rdy_i,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         overflow_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [LW-1:0] LEVEL_MAX = LW'(DEPTH);

    logic               bit_en;
    logic               word_done;
    logic [WIDTH-1:0]   new_word;
    logic               pop;
    logic               push_ok;

    logic [CW-1:0]      cnt_reg;
    logic [WIDTH-2:0]   shift_reg;
    logic [PW-1:0]      wr_ptr_reg;
    logic [PW-1:0]      rd_ptr_reg;
    logic [LW-1:0]      level_reg;
    logic               overflow_reg;
    logic [WIDTH-1:0]   mem [DEPTH];

    // Isolation masks the strobe so clamped bus values never reach the word path
    assign bit_en    = uin_MyBusS3.execute1 & ~isolate;
    assign word_done = bit_en && (cnt_reg == CNT_LAST);
    // The final bit bypasses the shift register and completes the word directly
    assign new_word  = {uin_MyBusS3.dataTx1, shift_reg};

    assign pop     = word_vld_o & word_rdy_i;
    // A pop in the same cycle frees the slot the new word needs
    assign push_ok = word_done && ((level_reg != LEVEL_MAX) || pop);

    // Bit counter: advances per strobe, wraps on word completion, cleared by isolation
    always_ff @(posedge ck or negedge arst_n) begin
        if (!arst_n) begin
            cnt_reg <= '0;
        end else if (isolate) begin
            cnt_reg <= '0;
        end else if (bit_en) begin
            cnt_reg <= word_done ? '0 : cnt_reg + CW'(1);
        end
    end

    // Shift register: each strobe stores its bit at the current bit position
    always_ff @(posedge ck or negedge arst_n) begin
        if (!arst_n) begin
            shift_reg <= '0;
        end else if (isolate) begin
            shift_reg <= '0;
        end else if (bit_en && !word_done) begin
            shift_reg[cnt_reg] <= uin_MyBusS3.dataTx1;
        end
    end

    // FIFO storage: written only when the completed word is accepted
    always_ff @(posedge ck or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr_reg] <= new_word;
        end
    end

    // Pointers, occupancy and sticky overflow; full/empty come from the level count
    always_ff @(posedge ck or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
            if (word_done && !push_ok) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign word_o     = mem[rd_ptr_reg];
    assign word_vld_o = (level_reg != '0);
    assign level_o    = level_reg;
    assign overflow_o = overflow_reg;

endmodule

// File: doc/s3_deserializer.md
# s3_deserializer

Stage directly downstream of the stage-2-to-stage-3 bridge: consumes the stage-3 bus (`execute1` qualifier, `dataTx1` serial bit) and assembles the serial bit stream into WIDTH-bit words. Completed words are buffered in a DEPTH-entry show-ahead FIFO and presented on a valid/ready output. An isolation input gates the bus during power-domain isolation so that clamped or garbage values never enter the word path. Overflow is flagged with a sticky bit rather than by applying backpressure, because the stage-3 bus has no stall.

## Interface
- WIDTH, 8: bits per assembled word; must be ≥ 2.
- DEPTH, 4: FIFO entries; power of 2, ≥ 2.
- ck  input  1  clock; all state updates on the rising edge.
- arst_n  input  1  asynchronous, active-low reset; one clock domain (ck).
- isolate  input  1  high = stage-3 bus isolated; bus inputs ignored.
- uin_MyBusS3  interface  in_MyBus  read-only use of `execute1` (1 bit, bit strobe) and `dataTx1` (1 bit, serial data); no interface signals driven.
- word_o  output  WIDTH  head-of-FIFO word; valid only when word_vld_o = 1.
- word_vld_o  output  1  FIFO not empty.
- word_rdy_i  input  1  consumer accepts word_o this cycle.
- level_o  output  $clog2(DEPTH+1)  current FIFO occupancy, 0..DEPTH.
- overflow_o  output  1  sticky; a completed word was dropped.

## Operation
- Bit strobe: bit_en = execute1 & ~isolate.
- Shift register and bit counter cnt (0..WIDTH-1). On bit_en, dataTx1 is captured LSB-first: the first bit of a word becomes bit 0.
- On bit_en with cnt = WIDTH-1, the word is complete: {dataTx1, shift[WIDTH-2:0]} is pushed and cnt returns to 0. Otherwise, on bit_en, cnt increments.
- Cycles with execute1 = 0 are gaps: cnt and the shift register hold, and a word may span any number of gap cycles.
- isolate = 1: cnt and the shift register clear synchronously, so any partial word is discarded. After isolate deasserts, the next bit_en is bit 0 of a new word. Words already in the FIFO are unaffected and still drain.
- FIFO:
  - pop = word_vld_o & word_rdy_i.
  - A push is accepted when level < DEPTH or when pop is asserted in the same cycle.
  - A push while full and not popping drops the new word (existing contents are preserved) and sets overflow_o.
  - Simultaneous push and pop: level is unchanged and order is preserved.
- word_o and word_vld_o are driven directly from registered FIFO state and read pointer. There is no combinational path from the bus to the outputs.
- overflow_o clears only on reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from level, never from pointer equality alone.

## Timing
- Reset (arst_n low, asynchronous assert) drives word_vld_o = 0, level_o = 0, overflow_o = 0, word_o = 0, cnt = 0, shift = 0, and both pointers = 0. Release is synchronous to ck (synchronized externally).
- Reset mid-word or with a non-empty FIFO discards all state. The first bit_en after release is bit 0.
- Latency: if the last bit of a word is sampled at edge N, word_vld_o and word_o are valid after edge N. With an empty FIFO that is one cycle after the last execute1 cycle.
- Throughput: one word every WIDTH bit_en cycles. Pop rate is one word per cycle.
- level_o updates on the same edge as the push/pop that causes the change.
- isolate and execute1 high in the same cycle: isolate wins, no bit is captured, and the partial word clears.
- Word completion coinciding with an isolate rising edge: the word is not completed, because bit_en = 0.

## Test plan
- Reset, then 8 bit_en cycles carrying 0xA5 LSB-first (1,0,1,0,0,1,0,1), word_rdy_i = 1 → word_vld_o high for exactly one cycle, after the 8th strobe edge, with word_o = 0xA5; level_o returns to 0.
- 0x3C sent with random 0–5 cycle gaps between strobes → single word 0x3C; no early or extra word_vld_o.
- 4 bits of 0xFF, isolate high for 3 cycles, then 8 bits of 0x12 → only 0x12 is output; no word is formed from the partial bits.
- word_rdy_i = 0; send 0x01..0x05 → level_o = 4 after 0x04; overflow_o = 1 after 0x05 completes; draining yields 0x01, 0x02, 0x03, 0x04 in order; overflow_o stays 1.
- FIFO full (0x10..0x13); 0x14 completes in the same cycle as a pop → pop returns 0x10, 0x14 is accepted, level_o stays 4, overflow_o stays 0; drain order is 0x11, 0x12, 0x13, 0x14.
- 2 words queued plus 5 bits of a third, then arst_n pulsed low mid-cycle → outputs are immediately 0, level_o = 0, overflow_o = 0; a subsequent 0x7E is received intact.
